nibble_serial_adder: RTL



---
 rtl/nibble_adder_pkg.sv | 16 +
 rtl/add4_slice.sv | 23 ++
 rtl/nibble_serial_adder.sv | 130 +++++++++++++
 3 files changed

// File: rtl/nibble_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nibble_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } nsa_state_e;

  function automatic int nibbles(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/add4_slice.sv
// Combinational 4-bit ripple-carry slice, one full adder per bit.
module add4_slice
  import nibble_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout
);

  logic [NIBBLE_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Adds two WIDTH-bit operands one nibble per cycle through a single 4-bit slice.
// Define NIBBLE_SERIAL_OVF_EN to add the signed-overflow output ovf.
module nibble_serial_adder
  import nibble_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef NIBBLE_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIBBLES = nibbles(WIDTH);
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

  nsa_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [NIBBLE_W-1:0] slice_sum;
  logic                slice_cout;
  logic [WIDTH-1:0]    sum_next;

  add4_slice u_slice (
    .a    (a_sh_q[NIBBLE_W-1:0]),
    .b    (b_sh_q[NIBBLE_W-1:0]),
    .cin  (carry_q),
    .s    (slice_sum),
    .cout (slice_cout)
  );

  // Result nibbles enter at the top so the LSB nibble ends at bit 0.
  if (WIDTH == NIBBLE_W) begin : g_sum_one
    assign sum_next = slice_sum;
  end else begin : g_sum_many
    assign sum_next = {slice_sum, sum_sh_q[WIDTH-1:NIBBLE_W]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        a_sh_d   = a_sh_q >> NIBBLE_W;
        b_sh_d   = b_sh_q >> NIBBLE_W;
        sum_sh_d = sum_next;
        carry_d  = slice_cout;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_sh_q;
  assign cout      = carry_q;

`ifdef NIBBLE_SERIAL_OVF_EN
  logic a_msb_q, b_msb_q, ovf_q;

  // Operand sign bits are gone from the shifters by the end, so keep copies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (state_q == IDLE && in_valid) begin
      a_msb_q <= a[WIDTH-1];
      b_msb_q <= b[WIDTH-1];
    end else if (state_q == BUSY && cnt_q == LAST) begin
      ovf_q <= (a_msb_q == b_msb_q) && (sum_next[WIDTH-1] != a_msb_q);
    end
  end

  assign ovf = ovf_q;
`endif

endmodule
